// File: rtl/stopwatch_pkg.sv
// Shared state encodings, default clocking and width helper for the stopwatch
// run/mode controller.
package stopwatch_pkg;

   localparam int STATE_W     = 3;
   localparam int DEF_CLK_HZ  = 50000000;
   localparam int DEF_TICK_HZ = 10;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      RUN_UP   = 3'd1,
      RUN_DOWN = 3'd2,
      PAUSED   = 3'd3,
      EXPIRED  = 3'd4
   } state_e;

   // Bits needed to hold 0..n-1; never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Button conditioner: metastability synchronizer followed by a registered
// rising-edge detector that emits a one-cycle press pulse.
module btn_sync_edge
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   press_q;

   // Flops preset high so a button held through reset release is not a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= {SYNC_STAGES{1'b1}};
         hist_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
         hist_q  <= sync_q[SYNC_STAGES-1];
         press_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

   assign press_pulse = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/mode controller: button conditioning, tenth-second prescaler,
// run/pause/expire sequencing and expired-display flashing.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ      = DEF_CLK_HZ,
   parameter int TICK_HZ     = DEF_TICK_HZ,
   parameter int FLASH_TICKS = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               clear,
   input  logic               countdown,
   input  logic               time_zero,
   input  logic               time_max,
   output logic               cnt_en,
   output logic               cnt_down,
   output logic               cnt_clr,
   output logic               tick_10hz,
   output logic               display_blank,
   output logic               running,
   output logic               expired,
   output logic [STATE_W-1:0] state
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = clog2(DIV);
   localparam int FW  = clog2(FLASH_TICKS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

   logic          start_p, stop_p, clear_p;
   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          flash_phase_q, flash_phase_d;
   logic          cnt_clr_q, cnt_clr_d;
   logic          blank_q, blank_d;
   logic          running_q, running_d;
   logic          expired_q, expired_d;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
      .clk(clk), .reset(reset), .btn_in(start), .press_pulse(start_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
      .clk(clk), .reset(reset), .btn_in(stop), .press_pulse(stop_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
      .clk(clk), .reset(reset), .btn_in(clear), .press_pulse(clear_p));

   // Next-state, prescaler, flash and step-command logic.
   always_comb begin
      state_d       = state_q;
      cnt_clr_d     = 1'b0;
      presc_d       = presc_q;
      flash_cnt_d   = flash_cnt_q;
      flash_phase_d = flash_phase_q;
      tick_10hz     = (presc_q == PRESC_LAST) &&
                      (state_q inside {RUN_UP, RUN_DOWN, EXPIRED});
      cnt_en        = tick_10hz &&
                      (((state_q == RUN_UP) && !time_max) ||
                       ((state_q == RUN_DOWN) && !time_zero));
      cnt_down      = (state_q == RUN_DOWN);

      // Clear beats stop, which beats start; a stop pulse swallows a same-cycle start.
      if (clear_p) begin
         state_d   = IDLE;
         cnt_clr_d = 1'b1;
      end else if (stop_p) begin
         case (state_q)
            RUN_UP, RUN_DOWN: state_d = PAUSED;
            EXPIRED:          state_d = IDLE;
            default:          state_d = state_q;
         endcase
      end else begin
         case (state_q)
            IDLE, PAUSED: begin
               if (start_p && !countdown && !time_max) begin
                  state_d = RUN_UP;
               end else if (start_p && countdown && !time_zero) begin
                  state_d = RUN_DOWN;
               end else begin
                  state_d = state_q;
               end
            end
            RUN_UP:   state_d = (tick_10hz && time_max) ? PAUSED : RUN_UP;
            RUN_DOWN: state_d = time_zero ? EXPIRED : RUN_DOWN;
            EXPIRED:  state_d = EXPIRED;
            default:  state_d = IDLE;
         endcase
      end

      case (state_q)
         IDLE:                      presc_d = {PW{1'b0}};
         PAUSED:                    presc_d = presc_q;
         RUN_UP, RUN_DOWN, EXPIRED: presc_d = (presc_q == PRESC_LAST) ? {PW{1'b0}}
                                                                      : presc_q + PW'(1'b1);
         default:                   presc_d = {PW{1'b0}};
      endcase

      // Expiry always opens with a visible half-period.
      if ((state_d == EXPIRED) && (state_q != EXPIRED)) begin
         flash_cnt_d   = {FW{1'b0}};
         flash_phase_d = 1'b1;
      end else if ((state_q == EXPIRED) && tick_10hz) begin
         if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d   = {FW{1'b0}};
            flash_phase_d = ~flash_phase_q;
         end else begin
            flash_cnt_d   = flash_cnt_q + FW'(1'b1);
            flash_phase_d = flash_phase_q;
         end
      end else if (state_q != EXPIRED) begin
         flash_cnt_d   = {FW{1'b0}};
         flash_phase_d = 1'b0;
      end else begin
         flash_cnt_d   = flash_cnt_q;
         flash_phase_d = flash_phase_q;
      end

      blank_d   = (state_d == EXPIRED) && !flash_phase_d;
      running_d = (state_d == RUN_UP) || (state_d == RUN_DOWN);
      expired_d = (state_d == EXPIRED);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         presc_q       <= {PW{1'b0}};
         flash_cnt_q   <= {FW{1'b0}};
         flash_phase_q <= 1'b0;
         cnt_clr_q     <= 1'b0;
         blank_q       <= 1'b0;
         running_q     <= 1'b0;
         expired_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         flash_cnt_q   <= flash_cnt_d;
         flash_phase_q <= flash_phase_d;
         cnt_clr_q     <= cnt_clr_d;
         blank_q       <= blank_d;
         running_q     <= running_d;
         expired_q     <= expired_d;
      end
   end

   assign state         = state_q;
   assign cnt_clr       = cnt_clr_q;
   assign display_blank = blank_q;
   assign running       = running_q;
   assign expired       = expired_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner cases and
// randomized stimulus against a behavioural model.
module tb_stopwatch_ctrl;

   localparam int CLK_HZ      = 100;
   localparam int TICK_HZ     = 10;
   localparam int FLASH_TICKS = 2;
   localparam int SYNC_STAGES = 2;
   localparam int DIV         = CLK_HZ / TICK_HZ;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0, stop = 1'b0, clear = 1'b0;
   logic countdown = 1'b0, time_zero = 1'b0, time_max = 1'b0;
   logic cnt_en, cnt_down, cnt_clr, tick_10hz, display_blank, running, expired;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FLASH_TICKS(FLASH_TICKS), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .countdown(countdown), .time_zero(time_zero), .time_max(time_max),
      .cnt_en(cnt_en), .cnt_down(cnt_down), .cnt_clr(cnt_clr), .tick_10hz(tick_10hz),
      .display_blank(display_blank), .running(running), .expired(expired), .state(state)
   );

   // Behavioural model: button history as delay lines, time base as plain integers.
   int m_state, m_presc, m_fcnt;
   bit m_phase, m_clr, m_blank;
   bit h_start[$], h_stop[$], h_clear[$];

   task automatic model_reset();
      m_state = 0; m_presc = 0; m_fcnt = 0;
      m_phase = 1'b0; m_clr = 1'b0; m_blank = 1'b0;
      h_start.delete(); h_stop.delete(); h_clear.delete();
      for (int i = 0; i < SYNC_STAGES + 2; i++) begin
         h_start.push_back(1'b1); h_stop.push_back(1'b1); h_clear.push_back(1'b1);
      end
   endtask

   function automatic bit m_tick();
      return (m_presc == DIV - 1) && (m_state == 1 || m_state == 2 || m_state == 4);
   endfunction

   task automatic model_update();
      bit ps, pp, pc, tk, clr;
      int nxt;
      ps = h_start[SYNC_STAGES] && !h_start[SYNC_STAGES+1];
      pp = h_stop[SYNC_STAGES]  && !h_stop[SYNC_STAGES+1];
      pc = h_clear[SYNC_STAGES] && !h_clear[SYNC_STAGES+1];
      h_start.push_front(start); void'(h_start.pop_back());
      h_stop.push_front(stop);   void'(h_stop.pop_back());
      h_clear.push_front(clear); void'(h_clear.pop_back());
      tk  = m_tick();
      nxt = m_state;
      clr = 1'b0;
      if (pc) begin
         nxt = 0; clr = 1'b1;
      end else if (pp) begin
         if (m_state == 1 || m_state == 2) nxt = 3;
         else if (m_state == 4) nxt = 0;
      end else if (m_state == 0 || m_state == 3) begin
         if (ps && !countdown && !time_max) nxt = 1;
         else if (ps && countdown && !time_zero) nxt = 2;
      end else if (m_state == 1) begin
         if (tk && time_max) nxt = 3;
      end else if (m_state == 2) begin
         if (time_zero) nxt = 4;
      end
      if (nxt == 4 && m_state != 4) begin
         m_fcnt = 0; m_phase = 1'b1;
      end else if (m_state == 4) begin
         if (tk) begin
            m_fcnt++;
            if (m_fcnt == FLASH_TICKS) begin m_fcnt = 0; m_phase = !m_phase; end
         end
      end else begin
         m_fcnt = 0; m_phase = 1'b0;
      end
      if (m_state == 0) m_presc = 0;
      else if (m_state != 3) m_presc = (m_presc + 1) % DIV;
      m_blank = (nxt == 4) && !m_phase;
      m_clr   = clr;
      m_state = nxt;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      bit [10:0] act, exp;
      bit tk;
      tk  = m_tick();
      act = {state, running, expired, cnt_clr, display_blank, tick_10hz, cnt_en, cnt_down};
      exp = {3'(m_state), (m_state == 1 || m_state == 2), (m_state == 4), m_clr, m_blank, tk,
             tk && ((m_state == 1 && !time_max) || (m_state == 2 && !time_zero)),
             (m_state == 2)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model: got %b expected %b (state,run,exp,clr,blank,tick,en,down) at %0t",
                  act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_update();
      @(negedge clk);
      compare_model();
   endtask

   task automatic wait_state(input string name, input int target, input int bound);
      int n;
      n = 0;
      while (int'(state) != target && n < bound) begin step(); n++; end
      check(name, int'(state), target);
   endtask

   task automatic press_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   typedef struct {
      bit st, sp, cl, cd, tz, tm;
      int cyc;
      int exp_state;
   } vec_t;
   vec_t vecs[18];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, pulses, seen, last_tick, saw3, clrs, len;
      bit cur;
      int runs[$];
      int vals[$];

      vecs[0]  = '{0,0,0,0,0,0, 3, 0};
      vecs[1]  = '{1,0,0,0,0,0, 1, 0};
      vecs[2]  = '{0,0,0,0,0,0, 4, 1};
      vecs[3]  = '{0,1,0,0,0,0, 1, 1};
      vecs[4]  = '{0,0,0,0,0,0, 4, 3};
      vecs[5]  = '{1,0,0,1,0,0, 1, 3};
      vecs[6]  = '{0,0,0,1,0,0, 4, 2};
      vecs[7]  = '{0,0,0,1,1,0, 2, 4};
      vecs[8]  = '{0,1,0,1,1,0, 1, 4};
      vecs[9]  = '{0,0,0,1,1,0, 4, 0};
      vecs[10] = '{1,0,0,1,1,0, 1, 0};
      vecs[11] = '{0,0,0,1,1,0, 4, 0};
      vecs[12] = '{1,0,0,0,0,1, 1, 0};
      vecs[13] = '{0,0,0,0,0,1, 4, 0};
      vecs[14] = '{1,0,0,0,0,0, 1, 0};
      vecs[15] = '{0,0,0,0,0,0, 4, 1};
      vecs[16] = '{0,0,1,0,0,0, 1, 1};
      vecs[17] = '{0,0,0,0,0,0, 4, 0};

      // Reset with start held: release must not register a press.
      model_reset();
      start = 1'b1;
      repeat (3) step();
      check("reset_state", int'(state), 0);
      reset = 1'b1;
      repeat (6) step();
      check("start_held_reset", int'(state), 0);
      start = 1'b0;
      repeat (4) step();

      for (int i = 0; i < 18; i++) begin
         start = vecs[i].st; stop = vecs[i].sp; clear = vecs[i].cl;
         countdown = vecs[i].cd; time_zero = vecs[i].tz; time_max = vecs[i].tm;
         for (int c = 0; c < vecs[i].cyc; c++) step();
         check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
         check($sformatf("vec%0d_running", i), int'(running),
               int'(vecs[i].exp_state == 1 || vecs[i].exp_state == 2));
      end
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      countdown = 1'b0; time_zero = 1'b0; time_max = 1'b0;
      repeat (3) step();

      // Press latency and first full tenth.
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      check("start_latency_early", int'(state), 0);
      step();
      check("start_latency", int'(state), 1);
      n = 0;
      while (!cnt_en && n < 30) begin step(); n++; end
      check("first_step_delay", n, 9);

      // Pause mid-tenth, then resume with the remaining count.
      clear = 1'b1; step(); clear = 1'b0;
      wait_state("clear_idle", 0, 10);
      press_start();
      wait_state("run_up_entry", 1, 10);
      pulses = 0;
      for (int i = 1; i <= 25; i++) begin
         if (i == 22) stop = 1'b1;
         step();
         stop = 1'b0;
         if (cnt_en) pulses++;
      end
      check("run25_pulses", pulses, 2);
      check("run25_paused", int'(state), 3);
      seen = 0;
      for (int i = 0; i < 17; i++) begin
         step();
         if (cnt_en || tick_10hz) seen++;
      end
      check("pause_no_tick", seen, 0);
      press_start();
      wait_state("resume_up", 1, 10);
      n = 0;
      while (!cnt_en && n < 30) begin step(); n++; end
      check("resume_remaining", n, 4);

      // Saturation at the top.
      repeat (3) step();
      time_max = 1'b1;
      #1;
      seen = 0; last_tick = 0; n = 0;
      while (int'(state) == 1 && n < 20) begin
         if (cnt_en) seen++;
         last_tick = int'(tick_10hz);
         step(); n++;
      end
      check("max_no_step", seen, 0);
      check("max_on_tick", last_tick, 1);
      check("max_paused", int'(state), 3);
      time_max = 1'b0;

      // Countdown expiry and flashing.
      countdown = 1'b1;
      press_start();
      wait_state("run_down_entry", 2, 10);
      repeat (12) step();
      time_zero = 1'b1;
      #1;
      check("expire_no_step", int'(cnt_en), 0);
      step();
      check("expire_state", int'(state), 4);
      check("expire_visible", int'(display_blank), 0);
      cur = display_blank; len = 1;
      for (int i = 0; i < 90; i++) begin
         step();
         if (display_blank == cur) len++;
         else begin runs.push_back(len); vals.push_back(int'(cur)); cur = display_blank; len = 1; end
      end
      check("flash_runs", int'(runs.size() >= 3), 1);
      if (runs.size() >= 3) begin
         check("flash_first_len", int'(runs[0] >= 11 && runs[0] <= 20), 1);
         check("flash_blank_len", runs[1], 20);
         check("flash_blank_val", vals[1], 1);
         check("flash_vis_len", runs[2], 20);
         check("flash_vis_val", vals[2], 0);
      end
      time_zero = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;
      clrs = 0;
      for (int i = 0; i < 8; i++) begin step(); if (cnt_clr) clrs++; end
      check("expired_clear_pulses", clrs, 1);
      check("expired_clear_state", int'(state), 0);
      check("expired_clear_blank", int'(display_blank), 0);

      // Simultaneous presses while counting down.
      countdown = 1'b1;
      press_start();
      wait_state("run_down_again", 2, 10);
      repeat (3) step();
      start = 1'b1; stop = 1'b1; clear = 1'b1;
      step();
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      saw3 = 0; clrs = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (int'(state) == 3) saw3++;
         if (cnt_clr) clrs++;
      end
      check("multi_no_pause", saw3, 0);
      check("multi_clr", clrs, 1);
      check("multi_idle", int'(state), 0);
      time_zero = 1'b1;
      press_start();
      repeat (6) step();
      check("down_at_zero_ignored", int'(state), 0);
      time_zero = 1'b0; countdown = 1'b0;

      // Asynchronous reset between clock edges.
      press_start();
      wait_state("run_before_reset", 1, 10);
      repeat (7) step();
      #2 reset = 1'b0;
      #1;
      check("async_reset_outputs",
            int'({state, running, expired, cnt_clr, display_blank, tick_10hz, cnt_en, cnt_down}), 0);
      model_reset();
      step(); step();
      reset = 1'b1;
      repeat (4) step();
      check("after_reset_idle", int'(state), 0);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom % 12 == 0);
         stop      = ($urandom % 20 == 0);
         clear     = ($urandom % 45 == 0);
         if ($urandom % 40 == 0) countdown = ~countdown;
         time_zero = ($urandom % 8 == 0);
         time_max  = ($urandom % 6 == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
